// File: rtl/afe_ro_pkg.sv
// -----------------------------------------------------------------------------
// afe_ro_pkg
// Shared definitions for the AFE readout buffer controller:
//   - default parameter widths
//   - word-to-byte address shift
//   - controller FSM state encoding
// -----------------------------------------------------------------------------
package afe_ro_pkg;

  localparam int AFE_RO_DATA_WIDTH_DEF = 32;
  localparam int AFE_RO_L2_AWIDTH_DEF  = 20;
  localparam int AFE_RO_SIZE_WIDTH_DEF = 16;
  localparam int AFE_RO_FIFO_DEPTH_DEF = 4;

  // Offsets count 32-bit words; the L2 port is byte addressed.
  localparam int AFE_RO_WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } afe_ro_state_t;

endpackage

// File: rtl/afe_ro_fifo.sv
// -----------------------------------------------------------------------------
// afe_ro_fifo
// Small synchronous FIFO holding accepted AFE samples until the L2 port
// takes them. Registered storage, so a pushed word is visible at o_head
// the cycle after the push.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   i_push        write i_data (ignored when full)
//   i_data        word to write
//   i_pop         drop head (ignored when empty)
//   i_flush       empty the FIFO; wins over push/pop
//   o_head        current head word
//   o_full        registered count == DEPTH
//   o_empty       registered count == 0
// -----------------------------------------------------------------------------
module afe_ro_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/afe_ro_buff_ctrl.sv
// -----------------------------------------------------------------------------
// afe_ro_buff_ctrl
// Takes synchronised AFE samples over valid/ready, queues them in a small
// FIFO and writes them as words into a linear or circular L2 buffer over a
// req/gnt port, raising an event when the last buffer word is granted.
//
// Handshakes:
//   afe_valid_i/afe_ready_o: a sample transfers on a cycle where both are 1.
//     Outside RUN ready is held 1 and transferred samples are discarded.
//   mem_req_o/mem_gnt_i: a word is written on a cycle where both are 1;
//     while req is high without gnt, addr and data hold steady.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cfg_en_i / cfg_clr_i     start pulse / stop-and-flush pulse (clr wins)
//   cfg_continuous_i         1 circular buffer, 0 single fill
//   cfg_base_addr_i          byte base address (word aligned)
//   cfg_size_i               buffer length in words (0 = do not start)
//   afe_valid_i/afe_data_i/afe_ready_o   sample input
//   mem_req_o/mem_addr_o/mem_data_o/mem_gnt_i   L2 write port
//   buff_full_evt_o          pulse the cycle after the last word is granted
//   busy_o                   FSM not IDLE
//   wr_offset_o              current word offset
//
// Build option AFE_RO_HALF_EVT_EN adds buff_half_evt_o, a pulse the cycle
// after the word at offset (size>>1)-1 is granted (never for size 1).
// -----------------------------------------------------------------------------
module afe_ro_buff_ctrl
  import afe_ro_pkg::*;
#(
  parameter int AFE_DATA_WIDTH = AFE_RO_DATA_WIDTH_DEF,
  parameter int L2_AWIDTH      = AFE_RO_L2_AWIDTH_DEF,
  parameter int SIZE_WIDTH     = AFE_RO_SIZE_WIDTH_DEF,
  parameter int FIFO_DEPTH     = AFE_RO_FIFO_DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      cfg_continuous_i,
  input  logic [L2_AWIDTH-1:0]      cfg_base_addr_i,
  input  logic [SIZE_WIDTH-1:0]     cfg_size_i,
  input  logic                      afe_valid_i,
  input  logic [AFE_DATA_WIDTH-1:0] afe_data_i,
  output logic                      afe_ready_o,
  output logic                      mem_req_o,
  output logic [L2_AWIDTH-1:0]      mem_addr_o,
  output logic [AFE_DATA_WIDTH-1:0] mem_data_o,
  input  logic                      mem_gnt_i,
  output logic                      buff_full_evt_o,
`ifdef AFE_RO_HALF_EVT_EN
  output logic                      buff_half_evt_o,
`endif
  output logic                      busy_o,
  output logic [SIZE_WIDTH-1:0]     wr_offset_o
);

  afe_ro_state_t             r_state;
  logic [L2_AWIDTH-1:0]      r_base;
  logic [SIZE_WIDTH-1:0]     r_size;
  logic [SIZE_WIDTH-1:0]     r_offset;
  logic                      r_continuous;
  logic                      r_full_evt;

  logic                      w_run;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [AFE_DATA_WIDTH-1:0] w_head;
  logic                      w_push;
  logic                      w_grant;
  logic                      w_last;
  logic                      w_flush;

  assign w_run = (r_state == ST_RUN);

  assign afe_ready_o     = ~w_run | ~w_fifo_full;
  assign mem_req_o       = w_run & ~w_fifo_empty;
  assign mem_data_o      = w_head;
  // Silent wrap at the top of the L2 byte space.
  assign mem_addr_o      = r_base + (L2_AWIDTH'(r_offset) << AFE_RO_WORD_SHIFT);
  assign busy_o          = (r_state != ST_IDLE);
  assign wr_offset_o     = r_offset;
  assign buff_full_evt_o = r_full_evt;

  // Only RUN keeps samples; IDLE/DONE accept and drop them.
  assign w_push  = afe_valid_i & afe_ready_o & w_run;
  // A grant coinciding with clr is discarded entirely.
  assign w_grant = mem_req_o & mem_gnt_i & ~cfg_clr_i;
  assign w_last  = w_grant & (r_offset == r_size - SIZE_WIDTH'(1));
  // Single-fill mode drops anything still queued once the buffer is full.
  assign w_flush = cfg_clr_i | (w_last & ~r_continuous);

  afe_ro_fifo #(
    .WIDTH (AFE_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (afe_data_i),
    .i_pop   (w_grant),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_size       <= '0;
      r_offset     <= '0;
      r_continuous <= 1'b0;
      r_full_evt   <= 1'b0;
    end else begin
      r_full_evt <= w_last;
      if (cfg_clr_i) begin
        r_state  <= ST_IDLE;
        r_offset <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cfg_en_i && (cfg_size_i != '0)) begin
              r_state      <= ST_RUN;
              r_offset     <= '0;
              r_base       <= cfg_base_addr_i;
              r_size       <= cfg_size_i;
              r_continuous <= cfg_continuous_i;
            end
          end
          ST_RUN: begin
            if (w_grant) begin
              if (w_last) begin
                r_offset <= '0;
                if (!r_continuous) begin
                  r_state <= ST_DONE;
                end
              end else begin
                r_offset <= r_offset + SIZE_WIDTH'(1);
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef AFE_RO_HALF_EVT_EN
  logic r_half_evt;
  logic w_half;

  assign w_half = w_grant & (r_size != SIZE_WIDTH'(1))
                & (r_offset == (r_size >> 1) - SIZE_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_half_evt <= 1'b0;
    end else begin
      r_half_evt <= w_half;
    end
  end

  assign buff_half_evt_o = r_half_evt;
`endif

endmodule

// File: tb/tb_afe_ro_buff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_afe_ro_buff_ctrl
// Directed scenarios plus randomized traffic for afe_ro_buff_ctrl. A
// behavioural model (mode, word offset, queue of pending samples) predicts
// every output each cycle; scenario-level checks use addresses and events
// logged from the DUT. Honours AFE_RO_HALF_EVT_EN when defined.
// -----------------------------------------------------------------------------
module tb_afe_ro_buff_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int SW    = 16;
  localparam int DEPTH = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_clr = 1'b0;
  logic          cfg_cont = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [SW-1:0] cfg_size = '0;
  logic          afe_valid = 1'b0;
  logic [DW-1:0] afe_data = '0;
  logic          afe_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_gnt = 1'b0;
  logic          full_evt;
  logic          busy;
  logic [SW-1:0] wr_offset;
`ifdef AFE_RO_HALF_EVT_EN
  logic          half_evt;
`endif

  always #5 clk = ~clk;

  afe_ro_buff_ctrl #(
    .AFE_DATA_WIDTH (DW),
    .L2_AWIDTH      (AW),
    .SIZE_WIDTH     (SW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_en_i         (cfg_en),
    .cfg_clr_i        (cfg_clr),
    .cfg_continuous_i (cfg_cont),
    .cfg_base_addr_i  (cfg_base),
    .cfg_size_i       (cfg_size),
    .afe_valid_i      (afe_valid),
    .afe_data_i       (afe_data),
    .afe_ready_o      (afe_ready),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_data_o       (mem_data),
    .mem_gnt_i        (mem_gnt),
    .buff_full_evt_o  (full_evt),
`ifdef AFE_RO_HALF_EVT_EN
    .buff_half_evt_o  (half_evt),
`endif
    .busy_o           (busy),
    .wr_offset_o      (wr_offset)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  int            m_mode = M_IDLE;
  int            m_off = 0;
  int            m_size = 0;
  int            m_base = 0;
  bit            m_cont = 1'b0;
  bit            m_full_p = 1'b0;
  bit            m_half_p = 1'b0;
  // observed from the DUT, for scenario checks
  logic [AW-1:0] wr_log[$];
  int            n_dut_full = 0;
  int            n_dut_half = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model with the
  // current inputs, then move to 1 time unit after the next rising edge.
  task automatic cycle();
    bit exp_ready;
    bit exp_req;
    bit pushed;
    bit granted;
    if (rst) begin
      m_mode = M_IDLE; m_off = 0; m_full_p = 0; m_half_p = 0;
      exp_q.delete();
    end else begin
      exp_ready = (m_mode != M_RUN) || (exp_q.size() < DEPTH);
      exp_req   = (m_mode == M_RUN) && (exp_q.size() != 0);
      chk("ready", afe_ready, exp_ready);
      chk("req", mem_req, exp_req);
      chk("busy", busy, m_mode != M_IDLE);
      chk("full_evt", full_evt, m_full_p);
`ifdef AFE_RO_HALF_EVT_EN
      chk("half_evt", half_evt, m_half_p);
      if (half_evt) n_dut_half++;
`endif
      if (full_evt) n_dut_full++;
      if (exp_req) begin
        chk("addr", mem_addr, (m_base + 4 * m_off) & 'hFFFFF);
        chk("data", mem_data, exp_q[0]);
      end
      if (m_mode != M_DONE) chk("offset", wr_offset, m_off);
      if (mem_req && mem_gnt && !cfg_clr) wr_log.push_back(mem_addr);

      m_full_p = 0;
      m_half_p = 0;
      if (cfg_clr) begin
        m_mode = M_IDLE; m_off = 0;
        exp_q.delete();
      end else if (m_mode == M_IDLE) begin
        if (cfg_en && cfg_size != 0) begin
          m_mode = M_RUN; m_off = 0;
          m_base = int'(cfg_base); m_size = int'(cfg_size); m_cont = cfg_cont;
        end
      end else if (m_mode == M_RUN) begin
        pushed  = afe_valid && exp_ready;
        granted = exp_req && mem_gnt;
        if (granted) begin
          void'(exp_q.pop_front());
          if (m_size > 1 && m_off == m_size / 2 - 1) m_half_p = 1;
          if (m_off == m_size - 1) begin
            m_full_p = 1;
            m_off = 0;
            if (!m_cont) m_mode = M_DONE;
          end else begin
            m_off++;
          end
        end
        if (m_mode == M_DONE) exp_q.delete();
        else if (pushed) exp_q.push_back(afe_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic arm(input int base, input int size, input bit cont);
    cfg_base = AW'(base); cfg_size = SW'(size); cfg_cont = cont;
    cfg_en = 1'b1;
    cycle();
    cfg_en = 1'b0;
  endtask

  task automatic clear();
    cfg_clr = 1'b1;
    cycle();
    cfg_clr = 1'b0;
  endtask

  task automatic run(input int n, input int p_valid, input int p_gnt);
    repeat (n) begin
      afe_valid = ($urandom_range(0, 99) < p_valid);
      afe_data  = $urandom;
      mem_gnt   = ($urandom_range(0, 99) < p_gnt);
      cycle();
    end
    afe_valid = 1'b0;
    mem_gnt   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    int            rbase;

    // reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_ready", afe_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_offset", wr_offset, 0);
    chk("rst_full_evt", full_evt, 0);
    run(3, 100, 100);

    // linear fill
    arm('h1000, 4, 0);
    wr_log.delete(); n_dut_full = 0;
    run(6, 100, 100);
    run(2, 100, 100);
    chk("lin_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk("lin_addr", wr_log[i], 'h1000 + 4 * i);
    chk("lin_nfull", n_dut_full, 1);
    chk("lin_busy_done", busy, 1);
    clear();

    // circular wrap
    arm('h2000, 3, 1);
    wr_log.delete(); n_dut_full = 0;
    run(7, 100, 100);
    run(3, 0, 100);
    chk("circ_nwrites", wr_log.size(), 7);
    for (int i = 0; i < 7 && i < wr_log.size(); i++)
      chk("circ_addr", wr_log[i], 'h2000 + 4 * (i % 3));
    chk("circ_nfull", n_dut_full, 2);
    chk("circ_offset", wr_offset, 1);
    clear();

    // backpressure
    arm('h0ABC0, 16, 0);
    run(6, 100, 0);
    chk("bp_ready_low", afe_ready, 0);
    hold_addr = mem_addr;
    hold_data = mem_data;
    run(3, 100, 0);
    chk("bp_addr_hold", mem_addr, hold_addr);
    chk("bp_data_hold", mem_data, hold_data);
    run(6, 0, 100);
    clear();

    // clear coinciding with grant at offset 2
    arm('h3000, 8, 0);
    n_dut_full = 0;
    afe_valid = 1'b1; mem_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      afe_data = $urandom;
      cfg_clr = (m_mode == M_RUN) && (exp_q.size() != 0) && (m_off == 2);
      if (cfg_clr) begin
        cycle();
        break;
      end
      cycle();
    end
    cfg_clr = 1'b0; afe_valid = 1'b0; mem_gnt = 1'b0;
    chk("clr_req", mem_req, 0);
    chk("clr_offset", wr_offset, 0);
    chk("clr_busy", busy, 0);
    run(3, 100, 100);
    chk("clr_nfull", n_dut_full, 0);

    // edge configs
    arm('h100, 0, 0);
    chk("size0_busy", busy, 0);
    cfg_clr = 1'b1;
    arm('h100, 5, 0);
    cfg_clr = 1'b0;
    chk("en_clr_busy", busy, 0);
    arm('h40, 1, 0);
    wr_log.delete();
    run(4, 100, 100);
    chk("size1_nwrites", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("size1_addr", wr_log[0], 'h40);
    clear();

    // top-of-L2 wrap
    arm('hFFFF8, 4, 1);
    run(12, 100, 100);
    clear();

    // randomized traffic
    for (int r = 0; r < 10; r++) begin
      rbase = int'($urandom & 'hFFFFC);
      arm(rbase, $urandom_range(1, 9), $urandom_range(0, 1));
      run(40, 70, 60);
      if ($urandom_range(0, 1) == 1) begin
        cfg_clr = 1'b1; mem_gnt = 1'b1;
        cycle();
        cfg_clr = 1'b0; mem_gnt = 1'b0;
      end
      run(5, 50, 50);
      clear();
    end

    // reset with a request pending
    arm('h500, 8, 0);
    run(3, 100, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstrun_req", mem_req, 0);
    chk("rstrun_offset", wr_offset, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_ready", afe_ready, 1);
    run(3, 100, 100);

`ifdef AFE_RO_HALF_EVT_EN
    arm('h800, 8, 1);
    n_dut_half = 0;
    run(16, 100, 100);
    run(2, 0, 100);
    chk("half_count", n_dut_half, 2);
    clear();
    arm('h900, 1, 1);
    n_dut_half = 0;
    run(6, 100, 100);
    chk("half_size1", n_dut_half, 0);
    clear();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/afe_ro_buff_ctrl.md
Name: afe_ro_buff_ctrl

Overview:
- Downstream consumer of the AFE synchroniser stage. Accepts synchronised AFE samples over a valid/ready handshake and queues them in a small FIFO.
- Writes them as 32-bit words into a linear or circular L2 buffer through a req/gnt memory port.
- Counts words against the configured buffer size and raises buffer events. Sits between the per-AFE sync interface and the L2 interconnect in the readout subsystem.

Parameters:
- AFE_DATA_WIDTH, 32, sample width; equals memory word width
- L2_AWIDTH, 20, byte-address width of the L2 port
- SIZE_WIDTH, 16, width of buffer size and offset counters (in words)
- FIFO_DEPTH, 4, sample FIFO entries; power of two, >=2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_en_i  in  1  start pulse; arms the buffer
- cfg_clr_i  in  1  stop/flush pulse
- cfg_continuous_i  in  1  1: circular buffer; 0: single fill then stop
- cfg_base_addr_i  in  L2_AWIDTH  buffer byte base address, word aligned
- cfg_size_i  in  SIZE_WIDTH  buffer length in words
- afe_valid_i  in  1  sample valid from sync stage
- afe_data_i  in  AFE_DATA_WIDTH  sample incl. channel ID field
- afe_ready_o  out  1  sample accepted when valid&ready
- mem_req_o  out  1  write request
- mem_addr_o  out  L2_AWIDTH  write byte address
- mem_data_o  out  AFE_DATA_WIDTH  write data
- mem_gnt_i  in  1  request granted this cycle
- buff_full_evt_o  out  1  one-cycle pulse on last word of buffer granted
- busy_o  out  1  FSM not IDLE
- wr_offset_o  out  SIZE_WIDTH  current word offset, for status readback

Behaviour:
- Reset (rst_i high at a clock edge): FSM=IDLE, FIFO empty, offset=0. All outputs 0 except afe_ready_o=1 (IDLE drops samples). Reset overrides everything, including a pending request.
- FSM states: IDLE, RUN, DONE.
  - IDLE: afe_ready_o=1; accepted samples are discarded. cfg_en_i with cfg_size_i!=0 -> RUN, offset=0, base/size/continuous latched. cfg_en_i with size 0 is ignored.
  - RUN: afe_ready_o = FIFO not full (registered count; no push-when-full even if a pop happens in the same cycle).
  - DONE: afe_ready_o=1, samples dropped, mem_req_o=0. Exits to IDLE only on cfg_clr_i. cfg_en_i in DONE is ignored.
- Memory port:
  - mem_req_o = FIFO not empty in RUN. mem_data_o = FIFO head; mem_addr_o = base + 4*offset.
  - Addr/data remain stable while req is high and gnt is low.
  - Grant pops the head and increments offset.
- Latency: a sample accepted at cycle N appears as mem_req_o at N+1 earliest (registered FIFO). Throughput is one word per cycle with a continuous grant.
- Last word (grant with offset==size-1): buff_full_evt_o pulses the next cycle.
  - continuous=0: -> DONE, remaining FIFO contents flushed.
  - continuous=1: offset wraps to 0, stays in RUN, no gap.
- Offset arithmetic is SIZE_WIDTH unsigned. Address addition truncates to L2_AWIDTH (silent wrap).
- cfg_clr_i: from any state -> IDLE next cycle. FIFO flushed, offset=0, mem_req_o=0. A grant in the same cycle as clr is not counted and fires no event.
- Simultaneous cfg_en_i and cfg_clr_i: clr wins; cfg_en must be re-issued.
- Simultaneous push and pop: both occur; count is unchanged.

Optional Feature:
- Macro: AFE_RO_HALF_EVT_EN.
- Defined: adds output buff_half_evt_o (1 bit), a one-cycle pulse the cycle after the grant of the word at offset == (size>>1)-1. It fires on each lap in continuous mode and never fires when size==1.
- Undefined: port and logic are absent.

Decomposition:
- Package afe_ro_pkg holds:
  - FSM state enum (IDLE/RUN/DONE)
  - word-to-byte shift constant (2)
  - default widths
- Sub-module afe_ro_fifo: sync FIFO with push/pop/flush, full/empty, depth FIFO_DEPTH, same reset.
- The controller instantiates a single afe_ro_fifo.

Test Plan:
- Linear fill: base=0x1000, size=4, continuous=0, 4 samples, gnt always 1 -> writes to 0x1000,0x1004,0x1008,0x100C in order, one buff_full_evt_o pulse, FSM=DONE, 5th sample dropped with afe_ready_o=1.
- Circular wrap: size=3, continuous=1, 7 samples -> addresses offset 0,1,2,0,1,2,0; two full-event pulses; wr_offset_o=1 at end.
- Backpressure: gnt held 0, FIFO_DEPTH=4 -> after 4 accepts afe_ready_o=0 and mem_addr_o/mem_data_o stay stable; release gnt -> drains at one word per cycle, ready returns the cycle after the first pop.
- Clear mid-run: size=8, clr asserted in the same cycle as a grant at offset 2 -> no further req, wr_offset_o=0, busy_o=0, no event.
- Edge configs: cfg_en with size=0 -> stays IDLE; cfg_en and cfg_clr together -> stays IDLE; size=1 linear -> one write then DONE.
- Reset mid-operation: rst_i with req pending -> next cycle req=0, offset=0, IDLE. With AFE_RO_HALF_EVT_EN defined, size=8 -> half event after the grant at offset 3.
